// File: rtl/song_mem_pkg.sv
// Shared types and slot-map helpers for the song memory controller.
package song_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PLAY     = 3'd1,
    ST_PLAY_RD  = 3'd2,
    ST_PLAY_LAT = 3'd3,
    ST_REC      = 3'd4,
    ST_DONE     = 3'd5
  } state_e;

  localparam logic [3:0] PRELOAD_MAX = 4'd5;
  localparam logic [3:0] USER_MIN    = 4'd8;
  localparam logic [3:0] USER_MAX    = 4'd13;

  function automatic logic slot_preload(input logic [3:0] slot);
    return slot <= PRELOAD_MAX;
  endfunction

  function automatic logic slot_valid(input logic [3:0] slot);
    return slot_preload(slot) || ((slot >= USER_MIN) && (slot <= USER_MAX));
  endfunction

endpackage

// File: rtl/song_len_table.sv
// Per-slot song length register file; preloaded slots come out of reset full.
module song_len_table
  import song_mem_pkg::*;
#(
  parameter int OFFSET_W = 14
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_we,
  input  logic [3:0]          i_waddr,
  input  logic [OFFSET_W:0]   i_wdata,
  input  logic [3:0]          i_raddr,
  output logic [OFFSET_W:0]   o_rdata
);

  localparam logic [OFFSET_W:0] LEN_FULL = {1'b1, {OFFSET_W{1'b0}}};

  logic [OFFSET_W:0] r_len [16];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        r_len[i] <= (i <= int'(PRELOAD_MAX)) ? LEN_FULL : '0;
      end
    end else if (i_we) begin
      r_len[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_len[i_raddr];

endmodule

// File: rtl/song_mem_ctrl.sv
// Record/playback sequencer between the ac97 sample strobe and an external BRAM.
// Define SONG_MEM_LOOP_EN to make playback wrap to the start of the song forever.
module song_mem_ctrl
  import song_mem_pkg::*;
#(
  parameter int OFFSET_W = 14,
  parameter int SAMPLE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ready,
  input  logic                  start_song,
  input  logic                  pause_song,
  input  logic                  record_mode,
  input  logic [3:0]            song_choice,
  input  logic [SAMPLE_W-1:0]   sample_in,
  output logic                  song_done,
  output logic [OFFSET_W+3:0]   mem_addr,
  output logic                  mem_we,
  output logic [SAMPLE_W-1:0]   mem_din,
  input  logic [SAMPLE_W-1:0]   mem_dout,
  output logic [SAMPLE_W-1:0]   sample_out,
  output logic                  sample_out_valid
);

`ifdef SONG_MEM_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam logic [OFFSET_W:0] OFF_MAX = {1'b0, {OFFSET_W{1'b1}}};

  state_e              r_state;
  logic [3:0]          r_slot;
  logic [OFFSET_W:0]   r_offset;
  logic                r_song_done;
  logic                r_mem_we;
  logic [OFFSET_W+3:0] r_mem_addr;
  logic [SAMPLE_W-1:0] r_mem_din;
  logic                r_vld_p0;
  logic [SAMPLE_W-1:0] r_sample_out;
  logic                r_sample_out_valid;

  logic [3:0]          w_len_raddr;
  logic [OFFSET_W:0]   w_len;
  logic [OFFSET_W:0]   w_off_inc;
  logic [OFFSET_W:0]   w_play_next;
  logic                w_rec_wr;
  logic                w_play_rd;
  logic                w_last;

  // The length lookup must see the new slot in the start cycle to catch empty songs.
  assign w_len_raddr = start_song ? song_choice : r_slot;
  assign w_off_inc   = r_offset + 1'b1;
  assign w_rec_wr    = (r_state == ST_REC) && ready && !pause_song && !start_song;
  assign w_play_rd   = (r_state == ST_PLAY) && ready && !pause_song && !start_song;
  assign w_last      = (w_off_inc == w_len);
  assign w_play_next = (w_last && LOOP_EN) ? '0 : w_off_inc;

  song_len_table #(.OFFSET_W(OFFSET_W)) u_len (
    .clk     (clk),
    .reset   (reset),
    .i_we    (w_rec_wr),
    .i_waddr (r_slot),
    .i_wdata (w_off_inc),
    .i_raddr (w_len_raddr),
    .o_rdata (w_len)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_slot      <= '0;
      r_offset    <= '0;
      r_song_done <= 1'b0;
      r_mem_we    <= 1'b0;
      r_vld_p0    <= 1'b0;
    end else begin
      r_song_done <= 1'b0;
      r_mem_we    <= 1'b0;
      r_vld_p0    <= 1'b0;
      if (start_song) begin
        r_slot   <= song_choice;
        r_offset <= '0;
        if (!slot_valid(song_choice) || (record_mode && slot_preload(song_choice)))
          r_state <= ST_DONE;
        else if (record_mode)
          r_state <= ST_REC;
        else if (w_len == '0)
          r_state <= ST_DONE;
        else
          r_state <= ST_PLAY;
      end else begin
        case (r_state)
          ST_REC: begin
            if (w_rec_wr) begin
              r_mem_we <= 1'b1;
              r_offset <= w_off_inc;
              if (r_offset == OFF_MAX) r_state <= ST_DONE;
            end
          end
          ST_PLAY: begin
            if (w_play_rd) begin
              r_vld_p0 <= 1'b1;
              r_offset <= w_play_next;
              r_state  <= (w_last && !LOOP_EN) ? ST_DONE : ST_PLAY_RD;
            end
          end
          ST_PLAY_RD:  r_state <= ST_PLAY_LAT;
          ST_PLAY_LAT: r_state <= ST_PLAY;
          ST_DONE: begin
            r_song_done <= 1'b1;
            r_state     <= ST_IDLE;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // p0 -> p1: the BRAM has answered the address presented with the ready strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem_addr         <= '0;
      r_mem_din          <= '0;
      r_sample_out       <= '0;
      r_sample_out_valid <= 1'b0;
    end else begin
      r_sample_out_valid <= r_vld_p0;
      if (r_vld_p0) r_sample_out <= mem_dout;
      if (start_song) begin
        r_mem_addr <= {song_choice, {OFFSET_W{1'b0}}};
      end else if (w_rec_wr) begin
        r_mem_addr <= {r_slot, r_offset[OFFSET_W-1:0]};
        r_mem_din  <= sample_in;
      end else if (w_play_rd) begin
        r_mem_addr <= {r_slot, w_play_next[OFFSET_W-1:0]};
      end
    end
  end

  assign song_done        = r_song_done;
  assign mem_we           = r_mem_we;
  assign mem_addr         = r_mem_addr;
  assign mem_din          = r_mem_din;
  assign sample_out       = r_sample_out;
  assign sample_out_valid = r_sample_out_valid;

endmodule

// File: tb/tb_song_mem_ctrl.sv
// Directed bench for song_mem_ctrl with a cycle-stamped event scoreboard and a BRAM model.
module tb_song_mem_ctrl;

`ifdef SONG_MEM_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  typedef struct { int cyc; logic [31:0] val; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  // DUT A: default geometry
  logic        reset = 1'b1, ready = 1'b0, start_song = 1'b0, pause_song = 1'b0, record_mode = 1'b0;
  logic [3:0]  song_choice = '0;
  logic [7:0]  sample_in = '0;
  logic        song_done, mem_we, sample_out_valid;
  logic [17:0] mem_addr;
  logic [7:0]  mem_din, sample_out;
  logic [7:0]  mem_dout = '0;

  // DUT B: OFFSET_W=3, write side only
  logic        ready_b = 1'b0, start_b = 1'b0, record_b = 1'b0;
  logic [3:0]  choice_b = '0;
  logic [7:0]  sample_in_b = '0;
  logic        song_done_b, mem_we_b, sample_out_valid_b;
  logic [6:0]  mem_addr_b;
  logic [7:0]  mem_din_b, sample_out_b;
  logic [7:0]  mem_dout_b = '0;

  song_mem_ctrl #(.OFFSET_W(14), .SAMPLE_W(8)) dut (
    .clk(clk), .reset(reset), .ready(ready), .start_song(start_song), .pause_song(pause_song),
    .record_mode(record_mode), .song_choice(song_choice), .sample_in(sample_in),
    .song_done(song_done), .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
    .mem_dout(mem_dout), .sample_out(sample_out), .sample_out_valid(sample_out_valid)
  );

  song_mem_ctrl #(.OFFSET_W(3), .SAMPLE_W(8)) dut_b (
    .clk(clk), .reset(reset), .ready(ready_b), .start_song(start_b), .pause_song(1'b0),
    .record_mode(record_b), .song_choice(choice_b), .sample_in(sample_in_b),
    .song_done(song_done_b), .mem_addr(mem_addr_b), .mem_we(mem_we_b), .mem_din(mem_din_b),
    .mem_dout(mem_dout_b), .sample_out(sample_out_b), .sample_out_valid(sample_out_valid_b)
  );

  // BRAM model: unwritten locations read back a fixed pattern of their address.
  logic [7:0] bram    [0:262143];
  bit         written [0:262143];

  function automatic logic [7:0] pat(input logic [17:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      bram[mem_addr]    <= mem_din;
      written[mem_addr] <= 1'b1;
    end
    mem_dout <= written[mem_addr] ? bram[mem_addr] : pat(mem_addr);
  end

  exp_t q_wr[$], q_smp[$], q_done[$], q_wr_b[$], q_done_b[$];
  exp_t e;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we) begin
      chk("wr_expected", 64'(q_wr.size() != 0), 64'd1);
      if (q_wr.size() != 0) begin
        e = q_wr.pop_front();
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
        chk("wr_addr_data", 64'({mem_addr, mem_din}), 64'(e.val));
      end
    end
    if (sample_out_valid) begin
      chk("smp_expected", 64'(q_smp.size() != 0), 64'd1);
      if (q_smp.size() != 0) begin
        e = q_smp.pop_front();
        chk("smp_cycle", 64'(cyc), 64'(e.cyc));
        chk("smp_value", 64'(sample_out), 64'(e.val));
      end
    end
    if (song_done) begin
      chk("done_expected", 64'(q_done.size() != 0), 64'd1);
      if (q_done.size() != 0) begin
        e = q_done.pop_front();
        chk("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (mem_we_b) begin
      chk("b_wr_expected", 64'(q_wr_b.size() != 0), 64'd1);
      if (q_wr_b.size() != 0) begin
        e = q_wr_b.pop_front();
        chk("b_wr_cycle", 64'(cyc), 64'(e.cyc));
        chk("b_wr_addr_data", 64'({mem_addr_b, mem_din_b}), 64'(e.val));
      end
    end
    if (song_done_b) begin
      chk("b_done_expected", 64'(q_done_b.size() != 0), 64'd1);
      if (q_done_b.size() != 0) begin
        e = q_done_b.pop_front();
        chk("b_done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (sample_out_valid_b) chk("b_smp_unexpected", 64'(sample_out_valid_b), 64'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic exp_wr(input logic [17:0] a, input logic [7:0] d);
    q_wr.push_back('{cyc + 1, 32'({a, d})});
  endtask

  task automatic exp_smp(input logic [7:0] d);
    q_smp.push_back('{cyc + 2, 32'(d)});
  endtask

  task automatic exp_done();
    q_done.push_back('{cyc + 2, 32'd1});
  endtask

  task automatic start(input logic [3:0] slot, input logic rec, input bit done);
    song_choice = slot;
    record_mode = rec;
    start_song  = 1'b1;
    if (done) exp_done();
    tick();
    start_song = 1'b0;
  endtask

  task automatic pulse_ready(input logic [7:0] d);
    sample_in = d;
    ready     = 1'b1;
    tick();
    ready     = 1'b0;
  endtask

  initial begin
    idle(3);
    chk("rst_song_done", 64'(song_done), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_din", 64'(mem_din), 64'd0);
    chk("rst_sample_out", 64'(sample_out), 64'd0);
    chk("rst_sample_valid", 64'(sample_out_valid), 64'd0);
    reset = 1'b0;
    idle(2);

    // Empty user slot, invalid slot, record onto preloaded and invalid slots.
    start(4'd9, 1'b0, 1'b1);  idle(4);
    start(4'd7, 1'b0, 1'b1);  idle(3);
    start(4'd3, 1'b1, 1'b1);  idle(3);
    start(4'd14, 1'b1, 1'b1); idle(3);

    // Preloaded slot 0: readies landing in PLAY_RD / PLAY_LAT are dropped.
    start(4'd0, 1'b0, 1'b0); idle(2);
    exp_smp(8'h5A);
    pulse_ready(8'h00);
    pulse_ready(8'h00);
    pulse_ready(8'h00);
    idle(1);
    exp_smp(8'h5B);
    pulse_ready(8'h00);
    idle(3);

    // Record slot 8 (aborting playback) with a pause in the middle.
    start(4'd8, 1'b1, 1'b0); idle(2);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        pause_song = 1'b1;
        for (int k = 0; k < 3; k++) begin
          pulse_ready(8'hEE);
          idle(1);
        end
        pause_song = 1'b0;
        idle(1);
      end
      exp_wr(18'h20000 + 18'(i), 8'h11 + 8'(i));
      pulse_ready(8'h11 + 8'(i));
      idle(2);
    end

    // Play slot 8 back, aborting the unfinished recording.
    start(4'd8, 1'b0, 1'b0); idle(2);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        pause_song = 1'b1;
        pulse_ready(8'h00);
        idle(1);
        pause_song = 1'b0;
      end
      exp_smp(8'h11 + 8'(i));
      if (i == 4 && !LOOP) exp_done();
      pulse_ready(8'h00);
      idle(3);
    end

    // Three-sample song on slot 10 played across seven readies.
    start(4'd10, 1'b1, 1'b0); idle(1);
    for (int i = 0; i < 3; i++) begin
      exp_wr(18'h28000 + 18'(i), 8'hA0 + 8'(i));
      pulse_ready(8'hA0 + 8'(i));
      idle(1);
    end
    start(4'd10, 1'b0, 1'b0); idle(2);
    for (int k = 0; k < 7; k++) begin
      if (LOOP) exp_smp(8'hA0 + 8'(k % 3));
      else if (k < 3) exp_smp(8'hA0 + 8'(k));
      if (!LOOP && k == 2) exp_done();
      pulse_ready(8'h00);
      idle(3);
    end
    start(4'd7, 1'b0, 1'b1); idle(3);

    // Reset in the middle of a recording: no done, lengths back to defaults.
    start(4'd9, 1'b1, 1'b0); idle(1);
    exp_wr(18'h24000, 8'h77);
    pulse_ready(8'h77);
    idle(1);
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(1);
    chk("rst2_sample_out", 64'(sample_out), 64'd0);
    chk("rst2_mem_addr", 64'(mem_addr), 64'd0);
    start(4'd9, 1'b0, 1'b1); idle(3);
    start(4'd8, 1'b0, 1'b1); idle(3);

    // Narrow instance: fill slot 8 completely, then one more ready.
    choice_b = 4'd8;
    record_b = 1'b1;
    start_b  = 1'b1;
    tick();
    start_b  = 1'b0;
    idle(1);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) q_wr_b.push_back('{cyc + 1, 32'({7'h40 + 7'(i), 8'hC0 + 8'(i)})});
      if (i == 7) q_done_b.push_back('{cyc + 2, 32'd1});
      sample_in_b = 8'hC0 + 8'(i);
      ready_b = 1'b1;
      tick();
      ready_b = 1'b0;
      idle(1);
    end
    idle(4);

    chk("left_wr", 64'(q_wr.size()), 64'd0);
    chk("left_smp", 64'(q_smp.size()), 64'd0);
    chk("left_done", 64'(q_done.size()), 64'd0);
    chk("left_wr_b", 64'(q_wr_b.size()), 64'd0);
    chk("left_done_b", 64'(q_done_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
